// File: rtl/cgra_exec_controller.sv
// cgra_exec_controller
// Loads configuration words into a PE array and sequences the shared context
// index through a mapping for a programmed number of full context sweeps.
module cgra_exec_controller #(
    parameter int PE_ROW_SIZE    = 4,
    parameter int PE_COLUMN_SIZE = 4,
    parameter int CONTEXT_SIZE   = 8,
    parameter int CONFIG_WIDTH   = 64,
    parameter int ITER_WIDTH     = 16
) (
    input  logic                                                       clk,
    input  logic                                                       reset,
    input  logic                                                       cfg_valid,
    output logic                                                       cfg_ready,
    input  logic [((PE_ROW_SIZE > 1) ? $clog2(PE_ROW_SIZE) : 1)-1:0]       cfg_row,
    input  logic [((PE_COLUMN_SIZE > 1) ? $clog2(PE_COLUMN_SIZE) : 1)-1:0] cfg_column,
    input  logic [((CONTEXT_SIZE > 1) ? $clog2(CONTEXT_SIZE) : 1)-1:0]     cfg_context,
    input  logic [CONFIG_WIDTH-1:0]                                    cfg_word,
    input  logic                                                       start,
    input  logic                                                       abort,
    input  logic                                                       stall,
    input  logic [((CONTEXT_SIZE > 1) ? $clog2(CONTEXT_SIZE) : 1)-1:0]     mapping_context_max_id,
    input  logic [ITER_WIDTH-1:0]                                      iteration_count,
    output logic [PE_ROW_SIZE*PE_COLUMN_SIZE-1:0]                      pe_write_config,
    output logic [CONFIG_WIDTH-1:0]                                    pe_config_word,
    output logic [((CONTEXT_SIZE > 1) ? $clog2(CONTEXT_SIZE) : 1)-1:0]     pe_config_index,
    output logic [((CONTEXT_SIZE > 1) ? $clog2(CONTEXT_SIZE) : 1)-1:0]     context_id,
    output logic                                                       exec_active,
    output logic                                                       busy,
    output logic                                                       done,
    output logic                                                       cfg_error
);

    localparam int RB  = (PE_ROW_SIZE > 1) ? $clog2(PE_ROW_SIZE) : 1;
    localparam int CB  = (PE_COLUMN_SIZE > 1) ? $clog2(PE_COLUMN_SIZE) : 1;
    localparam int XB  = (CONTEXT_SIZE > 1) ? $clog2(CONTEXT_SIZE) : 1;
    localparam int NPE = PE_ROW_SIZE * PE_COLUMN_SIZE;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [XB-1:0]           context_q, context_d;
    logic [XB-1:0]           max_q, max_d;
    logic [ITER_WIDTH-1:0]   iter_q, iter_d;
    logic [ITER_WIDTH-1:0]   count_q, count_d;
    logic [NPE-1:0]          strobe_q, strobe_d;
    logic [CONFIG_WIDTH-1:0] word_q, word_d;
    logic [XB-1:0]           index_q, index_d;
    logic                    cfg_error_q, cfg_error_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic [NPE-1:0]          pe_hit;
    logic                    ctx_in_range;
    logic                    addr_ok;
    logic                    cfg_accept;
    logic [XB-1:0]           clamped_max;
    logic                    last_context;
    logic                    last_iter;

    // One hit bit per physically present PE; an out-of-range row or column
    // matches nothing, which is how bad addresses are detected.
    for (genvar r = 0; r < PE_ROW_SIZE; r++) begin : g_row
        for (genvar c = 0; c < PE_COLUMN_SIZE; c++) begin : g_col
            assign pe_hit[r*PE_COLUMN_SIZE + c] = (cfg_row == RB'(r)) && (cfg_column == CB'(c));
        end
    end

    // Config handshake, address validation and run-control decode.
    always_comb begin
        ctx_in_range = (int'(cfg_context) < CONTEXT_SIZE);
        addr_ok      = (|pe_hit) && ctx_in_range;
        cfg_ready    = (state_q == ST_IDLE) && !start;
        cfg_accept   = cfg_valid && cfg_ready;
        clamped_max  = (int'(mapping_context_max_id) > CONTEXT_SIZE - 1)
                     ? XB'(CONTEXT_SIZE - 1) : mapping_context_max_id;
        last_context = (context_q == max_q);
        // iter_q < count_q throughout RUN, so iter_q + 1 cannot overflow.
        last_iter    = ((iter_q + 1'b1) == count_q);
    end

    // Next-state computation for the sequencer and the config write path.
    always_comb begin
        // NOTE: every _d starts from a default so no branch can leave it unassigned and infer a latch.
        state_d     = state_q;
        context_d   = context_q;
        max_d       = max_q;
        iter_d      = iter_q;
        count_d     = count_q;
        strobe_d    = '0;
        word_d      = word_q;
        index_d     = index_q;
        cfg_error_d = cfg_error_q;

        // A strobe lives for exactly the one cycle following acceptance; the
        // payload holds so the PEs see a stable bus between writes.
        if (cfg_accept) begin
            if (addr_ok) begin
                strobe_d = pe_hit;
                word_d   = cfg_word;
                index_d  = cfg_context;
            end else begin
                cfg_error_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    max_d     = clamped_max;
                    count_d   = iteration_count;
                    context_d = '0;
                    iter_d    = '0;
                    state_d   = (iteration_count == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                // Abort outranks both stall and the final wrap.
                if (abort) begin
                    state_d   = ST_IDLE;
                    context_d = '0;
                    iter_d    = '0;
                end else if (!stall) begin
                    if (last_context) begin
                        context_d = '0;
                        if (last_iter) begin
                            state_d = ST_DONE;
                            iter_d  = '0;
                        end else begin
                            iter_d = iter_q + 1'b1;
                        end
                    end else begin
                        context_d = context_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                context_d = '0;
                iter_d    = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State register for the FSM, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the wide payload register is reset as well, because the PEs observe it as zero out of reset.
            state_q     <= ST_IDLE;
            context_q   <= '0;
            max_q       <= '0;
            iter_q      <= '0;
            count_q     <= '0;
            strobe_q    <= '0;
            word_q      <= '0;
            index_q     <= '0;
            cfg_error_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            state_q     <= state_d;
            context_q   <= context_d;
            max_q       <= max_d;
            iter_q      <= iter_d;
            count_q     <= count_d;
            strobe_q    <= strobe_d;
            word_q      <= word_d;
            index_q     <= index_d;
            cfg_error_q <= cfg_error_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign pe_write_config = strobe_q;
    assign pe_config_word  = word_q;
    assign pe_config_index = index_q;
    assign context_id      = context_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign cfg_error       = cfg_error_q;
    // PE enable follows stall in the same cycle so a held context does no work.
    assign exec_active     = (state_q == ST_RUN) && !stall;

endmodule

// File: tb/tb_cgra_exec_controller.sv
// tb_cgra_exec_controller
// Self-checking bench: directed and randomized config writes and runs, with
// expected context traces derived from a flat work-item count.
module tb_cgra_exec_controller;

    // Non-power-of-two sizes so out-of-range rows and contexts are drivable.
    localparam int ROWS = 3;
    localparam int COLS = 4;
    localparam int CTXS = 6;
    localparam int CW   = 64;
    localparam int IW   = 16;
    localparam int RB   = 2;
    localparam int CB   = 2;
    localparam int XB   = 3;
    localparam int NPE  = ROWS * COLS;

    logic            clk = 1'b0;
    logic            reset;
    logic            cfg_valid;
    logic            cfg_ready;
    logic [RB-1:0]   cfg_row;
    logic [CB-1:0]   cfg_column;
    logic [XB-1:0]   cfg_context;
    logic [CW-1:0]   cfg_word;
    logic            start;
    logic            abort;
    logic            stall;
    logic [XB-1:0]   mapping_context_max_id;
    logic [IW-1:0]   iteration_count;
    logic [NPE-1:0]  pe_write_config;
    logic [CW-1:0]   pe_config_word;
    logic [XB-1:0]   pe_config_index;
    logic [XB-1:0]   context_id;
    logic            exec_active;
    logic            busy;
    logic            done;
    logic            cfg_error;

    int checks = 0;
    int errors = 0;
    bit exp_err = 1'b0;

    always #5 clk = ~clk;

    cgra_exec_controller #(
        .PE_ROW_SIZE    (ROWS),
        .PE_COLUMN_SIZE (COLS),
        .CONTEXT_SIZE   (CTXS),
        .CONFIG_WIDTH   (CW),
        .ITER_WIDTH     (IW)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .cfg_valid              (cfg_valid),
        .cfg_ready              (cfg_ready),
        .cfg_row                (cfg_row),
        .cfg_column             (cfg_column),
        .cfg_context            (cfg_context),
        .cfg_word               (cfg_word),
        .start                  (start),
        .abort                  (abort),
        .stall                  (stall),
        .mapping_context_max_id (mapping_context_max_id),
        .iteration_count        (iteration_count),
        .pe_write_config        (pe_write_config),
        .pe_config_word         (pe_config_word),
        .pe_config_index        (pe_config_index),
        .context_id             (context_id),
        .exec_active            (exec_active),
        .busy                   (busy),
        .done                   (done),
        .cfg_error              (cfg_error)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled 2 time units after the edge; inputs change there too.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic cfg_send(input int r, input int c, input int x, input logic [CW-1:0] w);
        bit bad;
        cfg_valid   = 1'b1;
        cfg_row     = RB'(r);
        cfg_column  = CB'(c);
        cfg_context = XB'(x);
        cfg_word    = w;
        #1 check("cfg_ready_idle", 64'(cfg_ready), 64'(1));
        tick();
        cfg_valid = 1'b0;
        bad = (r >= ROWS) || (c >= COLS) || (x >= CTXS);
        if (bad) begin
            exp_err = 1'b1;
            check("bad_no_strobe", 64'(pe_write_config), 64'(0));
        end else begin
            check("cfg_strobe", 64'(pe_write_config), 64'(1) << (r * COLS + c));
            check("cfg_index", 64'(pe_config_index), 64'(x));
            check("cfg_word", pe_config_word, w);
        end
        check("cfg_error", 64'(cfg_error), 64'(exp_err));
    endtask

    // Expected trace: work item k runs context k % (max+1); k advances only
    // on cycles where stall is low, and the run lasts iters*(max+1) items.
    task automatic do_run(input int max_in, input int iters, input int stall_at,
                          input int stall_len, input bit rand_stall, input int abort_at);
        int eff_max;
        int total;
        int k;
        int stall_cnt;
        eff_max   = (max_in > CTXS - 1) ? CTXS - 1 : max_in;
        total     = iters * (eff_max + 1);
        stall_cnt = 0;
        mapping_context_max_id = XB'(max_in);
        iteration_count        = IW'(iters);
        start = 1'b1;
        #1 check("ready_low_on_start", 64'(cfg_ready), 64'(0));
        tick();
        start = 1'b0;
        // Changes after start must not affect the run in progress.
        mapping_context_max_id = XB'($urandom);
        iteration_count        = IW'($urandom_range(0, 5));
        if (iters == 0) begin
            check("zero_iter_done", 64'(done), 64'(1));
            check("zero_iter_ctx", 64'(context_id), 64'(0));
            #1 check("zero_iter_no_exec", 64'(exec_active), 64'(0));
            tick();
            check("zero_iter_done_clear", 64'(done), 64'(0));
            check("zero_iter_idle", 64'(busy), 64'(0));
            return;
        end
        k = 0;
        while (k < total) begin
            check("run_busy", 64'(busy), 64'(1));
            check("run_done_low", 64'(done), 64'(0));
            check("run_ctx", 64'(context_id), 64'(k % (eff_max + 1)));
            check("run_no_strobe", 64'(pe_write_config), 64'(0));
            if (k == abort_at) begin
                abort = 1'b1;
                stall = 1'b1;
                #1 check("abort_exec_stalled", 64'(exec_active), 64'(0));
                tick();
                abort     = 1'b0;
                stall     = 1'b0;
                start     = 1'b0;
                cfg_valid = 1'b0;
                check("abort_idle", 64'(busy), 64'(0));
                check("abort_no_done", 64'(done), 64'(0));
                check("abort_ctx", 64'(context_id), 64'(0));
                #1 check("abort_ready", 64'(cfg_ready), 64'(1));
                tick();
                check("abort_no_late_done", 64'(done), 64'(0));
                return;
            end
            if (k == stall_at && stall_cnt < stall_len) begin
                stall = 1'b1;
                stall_cnt++;
            end else if (rand_stall) begin
                stall = ($urandom_range(0, 3) == 0);
            end else begin
                stall = 1'b0;
            end
            // Start and config offers are ignored while running.
            start       = 1'($urandom_range(0, 1));
            cfg_valid   = 1'($urandom_range(0, 1));
            cfg_row     = RB'($urandom_range(0, ROWS - 1));
            cfg_column  = CB'($urandom_range(0, COLS - 1));
            cfg_context = XB'($urandom_range(0, CTXS - 1));
            #1 check("exec_active", 64'(exec_active), 64'(!stall));
            check("run_not_ready", 64'(cfg_ready), 64'(0));
            tick();
            if (!stall) k++;
        end
        start     = 1'b0;
        stall     = 1'b0;
        cfg_valid = 1'b0;
        check("done_pulse", 64'(done), 64'(1));
        check("done_busy", 64'(busy), 64'(1));
        check("done_ctx", 64'(context_id), 64'(0));
        #1 check("done_no_exec", 64'(exec_active), 64'(0));
        tick();
        check("done_one_cycle", 64'(done), 64'(0));
        check("back_idle", 64'(busy), 64'(0));
        #1 check("idle_ready", 64'(cfg_ready), 64'(1));
    endtask

    initial begin
        int n_max;
        int n_it;
        int n_tot;
        int n_ab;
        reset = 1'b1;
        cfg_valid = 1'b0;
        cfg_row = '0;
        cfg_column = '0;
        cfg_context = '0;
        cfg_word = '0;
        start = 1'b0;
        abort = 1'b0;
        stall = 1'b0;
        mapping_context_max_id = '0;
        iteration_count = '0;
        tick();
        tick();

        // Reset values.
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_ctx", 64'(context_id), 64'(0));
        check("rst_strobe", 64'(pe_write_config), 64'(0));
        check("rst_word", pe_config_word, 64'(0));
        check("rst_index", 64'(pe_config_index), 64'(0));
        check("rst_err", 64'(cfg_error), 64'(0));
        check("rst_exec", 64'(exec_active), 64'(0));
        reset = 1'b0;
        #1 check("rst_ready", 64'(cfg_ready), 64'(1));

        // Directed write: row 1, column 2 lands on bit 1*4+2 = 6.
        cfg_send(1, 2, 3, 64'hA5);
        tick();
        check("strobe_one_cycle", 64'(pe_write_config), 64'(0));
        check("word_holds", pe_config_word, 64'hA5);

        // Back-to-back accepts give back-to-back strobes.
        cfg_valid = 1'b1; cfg_row = 2'd0; cfg_column = 2'd0; cfg_context = 3'd5; cfg_word = 64'h1111;
        tick();
        check("b2b_first", 64'(pe_write_config), 64'(1));
        cfg_row = 2'd2; cfg_column = 2'd3; cfg_context = 3'd1; cfg_word = 64'h2222;
        tick();
        cfg_valid = 1'b0;
        check("b2b_second", 64'(pe_write_config), 64'(1) << 11);
        check("b2b_word", pe_config_word, 64'h2222);
        check("b2b_index", 64'(pe_config_index), 64'(1));
        tick();

        // Random valid writes.
        for (int i = 0; i < 12; i++) begin
            cfg_send($urandom_range(0, ROWS - 1), $urandom_range(0, COLS - 1),
                     $urandom_range(0, CTXS - 1), {$urandom, $urandom});
        end

        // Directed runs.
        do_run(2, 3, -1, 0, 1'b0, -1);   // 0,1,2 x3 then done
        do_run(2, 3, 1, 2, 1'b0, -1);    // context 1 held 3 cycles
        do_run(7, 1, -1, 0, 1'b0, -1);   // clamped to CTXS-1
        do_run(0, 4, -1, 0, 1'b0, -1);   // one iteration per cycle
        do_run(2, 0, -1, 0, 1'b0, -1);   // zero iterations
        do_run(2, 3, -1, 0, 1'b0, 4);    // abort at context 1 of iteration 2
        do_run(2, 3, -1, 0, 1'b0, 5);    // abort on a wrap
        do_run(2, 3, -1, 0, 1'b0, 8);    // abort on the final wrap

        // Abort while idle is ignored and does not disturb a following run.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("idle_abort_ignored", 64'(busy), 64'(0));

        // Random runs.
        for (int i = 0; i < 8; i++) begin
            n_max = $urandom_range(0, 7);
            n_it  = $urandom_range(0, 4);
            n_tot = n_it * (((n_max > CTXS - 1) ? CTXS - 1 : n_max) + 1);
            n_ab  = -1;
            if (n_tot > 0 && $urandom_range(0, 2) == 0) n_ab = $urandom_range(0, n_tot - 1);
            do_run(n_max, n_it, -1, 0, 1'b1, n_ab);
        end

        // Bad addresses set a sticky error; good writes still work afterwards.
        cfg_send(3, 0, 0, 64'hDEAD);
        cfg_send(0, 1, 6, 64'hBEEF);
        cfg_send(2, 1, 4, 64'h1234);
        do_run(1, 1, -1, 0, 1'b0, -1);
        check("err_sticky", 64'(cfg_error), 64'(1));

        // Reset in the middle of a run.
        mapping_context_max_id = 3'd2;
        iteration_count = 16'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("pre_reset_ctx", 64'(context_id), 64'(2));
        reset = 1'b1;
        tick();
        check("midrun_rst_busy", 64'(busy), 64'(0));
        check("midrun_rst_done", 64'(done), 64'(0));
        check("midrun_rst_ctx", 64'(context_id), 64'(0));
        check("midrun_rst_strobe", 64'(pe_write_config), 64'(0));
        check("midrun_rst_word", pe_config_word, 64'(0));
        check("midrun_rst_index", 64'(pe_config_index), 64'(0));
        check("midrun_rst_err", 64'(cfg_error), 64'(0));
        check("midrun_rst_exec", 64'(exec_active), 64'(0));
        exp_err = 1'b0;
        reset = 1'b0;
        #1 check("midrun_rst_ready", 64'(cfg_ready), 64'(1));
        tick();
        check("midrun_rst_no_done", 64'(done), 64'(0));

        // Reset on the same edge as an accepted write drops the strobe.
        cfg_valid = 1'b1; cfg_row = 2'd1; cfg_column = 2'd1; cfg_context = 3'd2; cfg_word = 64'h77;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cfg_valid = 1'b0;
        check("cfg_rst_no_strobe", 64'(pe_write_config), 64'(0));
        check("cfg_rst_word", pe_config_word, 64'(0));
        tick();
        check("cfg_rst_still_no_strobe", 64'(pe_write_config), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
